quadrature_step_decoder: RTL and testbench
==========================================

Name: quadrature_step_decoder

Overview:
- Front-end stage that feeds the 4-bit asynchronous up/down counter.
- Takes raw quadrature encoder channels a/b, synchronises and glitch-filters them, and decodes Gray-code phase transitions.
- Produces a one-cycle `step` pulse and a direction level `m` that drive the counter's clock-enable and mode inputs.
- Detects illegal double-phase jumps and keeps a saturating error count.

Parameters:
- FILT_LEN, 3, consecutive synchronised samples required before a channel change is accepted (legal range 1..15).
- ERR_W, 4, width of the saturating error counter.

Ports:
- c  input  1  clock; all flops on rising edge.
- r  input  1  reset, asynchronous, active-low: asserts immediately, released synchronously to c by the system.
- a  input  1  encoder channel A, asynchronous to c.
- b  input  1  encoder channel B, asynchronous to c.
- err_clr  input  1  synchronous clear of err_cnt.
- step  output  1  one-cycle count pulse.
- m  output  1  direction: 0 = up, 1 = down (counter mode encoding).
- err  output  1  one-cycle illegal-transition pulse.
- err_cnt  output  ERR_W  saturating count of illegal transitions.
- rdy  output  1  high once the decoder is in RUN.

Behaviour:
- Reset (r=0) values:
  - Outputs: step=0, m=0, err=0, err_cnt=0, rdy=0.
  - Internal: synchroniser flops=0, filtered state {fa,fb}=00, filter counters=0, FSM=INIT.
- Synchroniser: two flops per channel; the synced value lags the pin by 2 edges.
- Glitch filter, per channel:
  - A counter increments while synced != filtered and clears when they are equal.
  - The filtered bit takes the synced value on the edge where they have differed for FILT_LEN consecutive edges; the counter clears on that edge.
  - Shorter pulses are discarded.
- FSM INIT:
  - Lasts FILT_LEN+2 cycles after reset release.
  - Filtered state copies the synced value every cycle.
  - step, err and err_cnt are suppressed.
  - Moves to RUN; rdy=1 from the first RUN cycle.
- FSM RUN: the filter is active and transitions are decoded.
- Decoding, on previous-to-new filtered state {fa,fb}:
  - Forward 00→01→11→10→00 is up (m=0).
  - Reverse is down (m=1).
  - No change: nothing.
  - Both bits change on the same edge (00↔11, 01↔10): illegal.
- Latency: a pin change sampled at edge N gives step=1 in the cycle after edge N+FILT_LEN+2, for exactly one cycle.
- m is registered and updates on the same edge that step rises; it holds otherwise.
- Illegal transition:
  - err=1 for one cycle at the same latency as step would have.
  - No step; m unchanged.
  - err_cnt increments and saturates at 2^ERR_W−1 (no wrap).
  - The filtered state still advances to the new value.
- err_clr=1: err_cnt becomes 0 on the next edge. If an error occurs in the same cycle, the clear wins (result 0); the err pulse still fires.
- step and err are never high in the same cycle.
- Reset mid-operation: everything returns to reset values immediately; after release INIT repeats, so a resting encoder at any phase produces no spurious step or err.

Optional Feature:
- Macro QDEC_X4_EN.
- Defined: x4 decoding. Every legal transition produces step, and m is updated on each.
- Undefined (default): x1 decoding.
  - Step only on legal transitions into state 00: 10→00 gives up, 01→00 gives down.
  - Other legal transitions update no outputs.
  - Illegal-transition handling is identical in both modes.

Test Plan:
- Reset then INIT, a=b=1 held: rdy rises after FILT_LEN+2=5 cycles; step, err and err_cnt stay 0 throughout.
- Forward sequence (x4): drive 00→01→11→10→00, each phase held 10 cycles → 4 step pulses, each 1 cycle wide, m=0, first pulse 5 cycles after the a/b change edge.
- Reverse sequence (x4 and x1): 00→10→11→01→00 → x4 gives 4 steps with m=1; x1 gives 1 step with m=1 on 01→00.
- Glitch: a pulses high for 2 cycles (FILT_LEN=3) → no step, no err, filtered state stays 00.
- Illegal jump: a and b toggle together 00→11 sixteen times with ERR_W=4 → err pulses 16×, err_cnt stops at 15, no step; then err_clr for 1 cycle → err_cnt=0.
- Reset mid-motion: assert r=0 between steps 2 and 3 → outputs drop to reset values at once; after release no step before rdy=1, and decoding resumes from the current encoder phase.

Source files
------------

// File: rtl/quadrature_step_decoder.sv
// rtl/quadrature_step_decoder.sv - quadrature encoder front end: sync, glitch filter, Gray decode
//
// Ports:
//   c        clock, rising edge
//   r        asynchronous active-low reset
//   a, b     raw encoder channels, asynchronous to c
//   err_clr  synchronous clear of err_cnt
//   step     one-cycle count pulse for the downstream counter
//   m        direction level, 0 = up, 1 = down
//   err      one-cycle pulse on an illegal double-phase jump
//   err_cnt  saturating count of illegal jumps
//   rdy      high once the decoder has left INIT
//
// Build option QDEC_X4_EN: step on every legal transition (x4).
// Without it, step only on legal entries into phase 00 (x1).

module quadrature_step_decoder #(
   parameter int FILT_LEN = 3,
   parameter int ERR_W    = 4
) (
   input  logic             c,
   input  logic             r,
   input  logic             a,
   input  logic             b,
   input  logic             err_clr,
   output logic             step,
   output logic             m,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             rdy
);

   localparam logic [3:0]       FILT_LAST = 4'(FILT_LEN - 1);
   localparam logic [4:0]       INIT_LAST = 5'(FILT_LEN + 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t     state_q, state_d;
   logic [4:0] init_cnt_q, init_cnt_d;

   // bit 1 = channel A, bit 0 = channel B throughout
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] filt_q, filt_d;
   logic [1:0] prev_q, prev_d;
   logic [3:0] fcnt_q [2];
   logic [3:0] fcnt_d [2];

   logic fwd, rev, ill;
   logic step_d, err_d;

   // State register and pipeline flops
   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         filt_q     <= '0;
         prev_q     <= '0;
         fcnt_q[0]  <= '0;
         fcnt_q[1]  <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         sync1_q    <= {a, b};
         sync2_q    <= sync1_q;
         filt_q     <= filt_d;
         prev_q     <= prev_d;
         fcnt_q[0]  <= fcnt_d[0];
         fcnt_q[1]  <= fcnt_d[1];
      end
   end

   // Next state, filter update
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      filt_d     = filt_q;
      prev_d     = filt_q;
      fcnt_d[0]  = fcnt_q[0];
      fcnt_d[1]  = fcnt_q[1];
      case (state_q)
         ST_INIT: begin
            // Track the pins directly so a resting encoder at any phase
            // leaves INIT with no pending transition.
            filt_d     = sync2_q;
            prev_d     = sync2_q;
            fcnt_d[0]  = '0;
            fcnt_d[1]  = '0;
            init_cnt_d = init_cnt_q + 5'd1;
            if (init_cnt_q == INIT_LAST) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            for (int i = 0; i < 2; i++) begin
               if (sync2_q[i] != filt_q[i]) begin
                  if (fcnt_q[i] == FILT_LAST) begin
                     filt_d[i] = sync2_q[i];
                     fcnt_d[i] = '0;
                  end else begin
                     fcnt_d[i] = fcnt_q[i] + 4'd1;
                  end
               end else begin
                  fcnt_d[i] = '0;
               end
            end
         end
      endcase
   end

   // Classify the last filtered move, {previous, current}
   always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      ill = 1'b0;
      case ({prev_q, filt_q})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev = 1'b1;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ill = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      step_d = 1'b0;
      err_d  = 1'b0;
      if (state_q == ST_RUN) begin
`ifdef QDEC_X4_EN
         step_d = fwd | rev;
`else
         step_d = (fwd | rev) & (filt_q == 2'b00);
`endif
         err_d  = ill;
      end
   end

   // Registered outputs
   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         step    <= 1'b0;
         m       <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         step <= step_d;
         err  <= err_d;
         if (step_d) begin
            m <= rev;
         end
         // Clear takes priority over a coincident increment
         if (err_clr) begin
            err_cnt <= '0;
         end else if (err_d && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

   assign rdy = (state_q == ST_RUN);

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// tb/tb_quadrature_step_decoder.sv - self-checking bench for quadrature_step_decoder

module tb_quadrature_step_decoder;

   localparam int FILT_LEN = 3;
   localparam int ERR_W    = 4;
   localparam int ERR_MAX  = 15;
   localparam int INIT_LEN = FILT_LEN + 2;

   logic             c = 1'b0;
   logic             r = 1'b0;
   logic             a = 1'b0;
   logic             b = 1'b0;
   logic             err_clr = 1'b0;
   logic             step, m, err, rdy;
   logic [ERR_W-1:0] err_cnt;

   int checks = 0;
   int errors = 0;
   int n_step = 0;
   int n_err  = 0;

   quadrature_step_decoder #(.FILT_LEN(FILT_LEN), .ERR_W(ERR_W)) dut (
      .c(c), .r(r), .a(a), .b(b), .err_clr(err_clr),
      .step(step), .m(m), .err(err), .err_cnt(err_cnt), .rdy(rdy)
   );

   always #5 c = ~c;

   // Reference model: pin history window, filtered phase, pending move
   int         k;
   bit         ha [0:31];
   bit         hb [0:31];
   logic [1:0] mf, pend_old, pend_new;
   bit         pend;
   bit         ms, ss, es, rs;
   int         ecnt;

   function automatic int gray_idx(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      k = 0;
      for (int i = 0; i < 32; i++) begin
         ha[i] = 1'b0;
         hb[i] = 1'b0;
      end
      mf = 2'b00; pend = 1'b0; pend_old = 2'b00; pend_new = 2'b00;
      ms = 1'b0; ss = 1'b0; es = 1'b0; rs = 1'b0; ecnt = 0;
   endtask

   task automatic model_edge(input bit pa, input bit pb, input bit clr);
      logic [1:0] nf;
      bit all_a, all_b;
      int d;
      k++;
      for (int i = 31; i > 0; i--) begin
         ha[i] = ha[i-1];
         hb[i] = hb[i-1];
      end
      ha[0] = pa;
      hb[0] = pb;
      ss = 1'b0;
      es = 1'b0;
      if (k <= INIT_LEN) begin
         mf   = {ha[2], hb[2]};
         pend = 1'b0;
      end else begin
         if (pend) begin
            d = (gray_idx(pend_new) - gray_idx(pend_old) + 4) % 4;
            if (d == 2) begin
               es = 1'b1;
            end else begin
`ifdef QDEC_X4_EN
               ss = 1'b1;
               ms = (d == 3);
`else
               if (pend_new == 2'b00) begin
                  ss = 1'b1;
                  ms = (d == 3);
               end
`endif
            end
         end
         pend = 1'b0;
         // A channel change is accepted once the last FILT_LEN synced
         // samples all disagree with the filtered value.
         all_a = 1'b1;
         all_b = 1'b1;
         for (int i = 2; i <= FILT_LEN + 1; i++) begin
            if (ha[i] == mf[1]) all_a = 1'b0;
            if (hb[i] == mf[0]) all_b = 1'b0;
         end
         nf = mf;
         if (all_a) nf[1] = ~mf[1];
         if (all_b) nf[0] = ~mf[0];
         if (nf != mf) begin
            pend     = 1'b1;
            pend_old = mf;
            pend_new = nf;
            mf       = nf;
         end
      end
      if (clr) ecnt = 0;
      else if (es && ecnt < ERR_MAX) ecnt++;
      rs = (k >= INIT_LEN);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input bit na, input bit nb, input bit clr);
      a = na;
      b = nb;
      err_clr = clr;
      @(posedge c);
      if (r) model_edge(na, nb, clr);
      else   model_reset();
      #1;
      check("outputs{step,m,err,rdy,err_cnt}",
            int'({step, m, err, rdy, err_cnt}),
            int'({ss, ms, es, rs, 4'(ecnt)}));
      if (step) n_step++;
      if (err)  n_err++;
   endtask

   task automatic hold(input bit na, input bit nb, input int n);
      for (int i = 0; i < n; i++) tick(na, nb, 1'b0);
   endtask

   typedef struct {
      bit a;
      bit b;
      int steps;
      int errs;
      bit m;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int first;
      int cur;
      int sel;
      int len;
      logic [1:0] ph;
      logic [1:0] seq [4];

      seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;

`ifdef QDEC_X4_EN
      tbl[0]  = '{1'b0, 1'b1, 1, 0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1, 0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1, 0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1, 0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1, 0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1, 0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1, 0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1, 0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 0, 1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 0, 1, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 1, 0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 0, 1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1, 0, 1'b0};
`else
      tbl[0]  = '{1'b0, 1'b1, 0, 0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 0, 0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 0, 0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1, 0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 0, 0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 0, 0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 0, 0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1, 0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 0, 1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 0, 1, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 0, 0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 0, 1, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1, 0, 1'b0};
`endif

      // Reset, then INIT with the encoder resting at 11
      model_reset();
      hold(1'b1, 1'b1, 3);
      check("reset_rdy", int'(rdy), 0);
      r = 1'b1;
      n_step = 0; n_err = 0;
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1, 1'b1, 1'b0);
         check("init_rdy", int'(rdy), (i >= INIT_LEN) ? 1 : 0);
      end
      check("init_steps", n_step, 0);
      check("init_errs", n_err, 0);

      // Walk to 00, then measure latency of 10 -> 00
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 10);
      hold(1'b1, 1'b0, 10);
      first = 0;
      for (int i = 1; i <= 10; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         if (step && first == 0) first = i;
      end
      check("latency", first, FILT_LEN + 3);

      // Table of phase moves from 00
      for (int i = 0; i < 13; i++) begin
         n_step = 0; n_err = 0;
         hold(tbl[i].a, tbl[i].b, 10);
         check($sformatf("tbl%0d_steps", i), n_step, tbl[i].steps);
         check($sformatf("tbl%0d_errs", i), n_err, tbl[i].errs);
         check($sformatf("tbl%0d_m", i), int'(m), int'(tbl[i].m));
      end
      check("tbl_err_cnt", int'(err_cnt), 3);

      // Glitch shorter than FILT_LEN is dropped
      n_step = 0; n_err = 0;
      hold(1'b1, 1'b0, FILT_LEN - 1);
      hold(1'b0, 1'b0, 12);
      check("glitch_steps", n_step, 0);
      check("glitch_errs", n_err, 0);

      // Pulse of exactly FILT_LEN is accepted both ways
      n_step = 0; n_err = 0;
      hold(1'b1, 1'b0, FILT_LEN);
      hold(1'b0, 1'b0, 12);
`ifdef QDEC_X4_EN
      check("edge_pulse_steps", n_step, 2);
`else
      check("edge_pulse_steps", n_step, 1);
`endif
      check("edge_pulse_errs", n_err, 0);

      // Sixteen illegal jumps saturate the counter
      tick(1'b0, 1'b0, 1'b1);
      n_step = 0; n_err = 0;
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) hold(1'b1, 1'b1, 8);
         else            hold(1'b0, 1'b0, 8);
      end
      check("sat_errs", n_err, 16);
      check("sat_steps", n_step, 0);
      check("sat_err_cnt", int'(err_cnt), ERR_MAX);
      tick(1'b0, 1'b0, 1'b1);
      check("clr_err_cnt", int'(err_cnt), 0);

      // Clear coinciding with an error wins; pulse still fires
      hold(1'b1, 1'b1, 8);
      check("one_err_cnt", int'(err_cnt), 1);
      hold(1'b0, 1'b0, FILT_LEN + 2);
      tick(1'b0, 1'b0, 1'b1);
      check("clr_win_err", int'(err), 1);
      check("clr_win_cnt", int'(err_cnt), 0);
      hold(1'b0, 1'b0, 6);

      // Reset mid-motion between the second and third step
      hold(1'b0, 1'b1, 10);
      hold(1'b1, 1'b1, 10);
      hold(1'b1, 1'b0, 2);
      #2;
      r = 1'b0;
      #1;
      check("async_reset_outs", int'({step, m, err, rdy, err_cnt}), 0);
      model_reset();
      hold(1'b1, 1'b0, 2);
      r = 1'b1;
      n_step = 0; n_err = 0;
      for (int i = 0; i < INIT_LEN; i++) begin
         tick(1'b1, 1'b0, 1'b0);
      end
      check("post_reset_rdy", int'(rdy), 1);
      hold(1'b1, 1'b0, 8);
      check("post_reset_steps", n_step, 0);
      check("post_reset_errs", n_err, 0);
      hold(1'b0, 1'b0, 10);
      check("resume_steps", n_step, 1);
      check("resume_m", int'(m), 0);

      // Randomised walk with short holds, jumps and clears
      cur = 0;
      for (int s = 0; s < 600; s++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      cur = (cur + 2) % 4;
         else if (sel <= 4) cur = (cur + 1) % 4;
         else if (sel <= 8) cur = (cur + 3) % 4;
         ph  = seq[cur];
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            tick(ph[1], ph[0], ($urandom_range(0, 15) == 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
